// File: rtl/gray_seq_gen.sv
// gray_seq_gen: registered Gray-code sequence generator feeding a Gray-to-binary converter.
// It supports single steps, a self-timed full-range sweep, and a parallel load from a binary value.
// Optional build macro GRAY_SEQ_CHECK_EN adds a sticky adjacency checker that drives err.
// When the macro is not defined, err is tied low.
module gray_seq_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] g,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  // The sweep counter needs one extra bit to hold the full code count 2^WIDTH.
  localparam int unsigned     CNT_W     = WIDTH + 1;
  localparam logic [CNT_W-1:0] NUM_CODES = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] MAX_BIN   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] g_d;
  logic             valid_d, busy_d, done_d, wrap_d;
  logic             step_chk;

  logic [WIDTH-1:0] bin_inc, bin_dec;
  logic             at_max, at_zero;

  // Step candidates shared by IDLE single steps and SWEEP steps.
  always_comb begin
    bin_inc = bin_q + WIDTH'(1);
    bin_dec = bin_q - WIDTH'(1);
    at_max  = (bin_q == MAX_BIN);
    at_zero = (bin_q == '0);
  end

  // State, binary counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      g       <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      g       <= g_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
      wrap    <= wrap_d;
    end
  end

  // Next-state and next-output logic; load beats start, and start beats en.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    step_chk = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d   = load_val;
          valid_d = 1'b1;
        end else if (start) begin
          bin_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          dir_d   = up;
          cnt_d   = CNT_W'(1);
          state_d = ST_SWEEP;
        end else if (en) begin
          bin_d    = up ? bin_inc : bin_dec;
          wrap_d   = up ? at_max : at_zero;
          valid_d  = 1'b1;
          step_chk = 1'b1;
        end
      end

      ST_SWEEP: begin
        if (load) begin
          // Abort: the sweep ends without a done pulse.
          bin_d   = load_val;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == NUM_CODES) begin
          // The last code is already out; bin holds it through DONE.
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          bin_d    = dir_q ? bin_inc : bin_dec;
          wrap_d   = dir_q ? at_max : at_zero;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          step_chk = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (load) begin
          bin_d   = load_val;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    g_d = bin_d ^ (bin_d >> 1);
  end

`ifdef GRAY_SEQ_CHECK_EN
  // Sticky adjacency check: the g register is the previous code when a step is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (step_chk && !$onehot(g_d ^ g)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_step_chk;
  assign unused_step_chk = step_chk;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed testbench for gray_seq_gen at WIDTH=4.
// It applies a table of single-cycle vectors, then hand-written sweep, abort and reset sequences.
module tb_gray_seq_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] g;
  logic       valid;
  logic       busy;
  logic       done;
  logic       wrap;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  gray_seq_gen #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .g        (g),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       en;
    logic       up;
    logic [3:0] exp_g;
    logic       exp_valid;
    logic       exp_wrap;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[12];

  // Up-sweep codes, written out by hand.
  logic [3:0] up_codes[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    en       = 1'b0;
    up       = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    vecs[0]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd5,  1'b1, 1'b1, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0};

    up_codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    // Reset state.
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst.g", 32'(g), 32'd0);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.wrap", 32'(wrap), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single-cycle vectors.
    for (int i = 0; i < 12; i++) begin
      load     = vecs[i].load;
      load_val = vecs[i].load_val;
      start    = vecs[i].start;
      en       = vecs[i].en;
      up       = vecs[i].up;
      tick();
      chk($sformatf("vec%0d.g", i), 32'(g), 32'(vecs[i].exp_g));
      chk($sformatf("vec%0d.valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d.done", i), 32'(done), 32'd0);
    end
    idle_inputs();

    // Up sweep; en and up toggle during the sweep and must be ignored.
    start = 1'b1;
    up    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("up%0d.g", i), 32'(g), 32'(up_codes[i]));
      chk($sformatf("up%0d.valid", i), 32'(valid), 32'd1);
      chk($sformatf("up%0d.busy", i), 32'(busy), 32'd1);
      chk($sformatf("up%0d.wrap", i), 32'(wrap), 32'd0);
      chk($sformatf("up%0d.done", i), 32'(done), 32'd0);
      start = 1'b0;
      en    = 1'b1;
      up    = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    tick();
    chk("up.done_pulse", 32'(done), 32'd1);
    chk("up.done_valid", 32'(valid), 32'd0);
    chk("up.done_busy", 32'(busy), 32'd0);
    chk("up.done_g", 32'(g), 32'b1000);
    // en held high while in DONE must not step.
    tick();
    chk("up.after_done", 32'(done), 32'd0);
    chk("up.after_valid", 32'(valid), 32'd0);
    chk("up.after_g", 32'(g), 32'b1000);
    chk("up.err", 32'(err), 32'd0);
    idle_inputs();

    // Down sweep; up toggles high and must be ignored.
    start = 1'b1;
    up    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] b;
      tick();
      b = 4'(16 - i);
      chk($sformatf("dn%0d.g", i), 32'(g), 32'(gray4(b)));
      chk($sformatf("dn%0d.valid", i), 32'(valid), 32'd1);
      chk($sformatf("dn%0d.busy", i), 32'(busy), 32'd1);
      chk($sformatf("dn%0d.wrap", i), 32'(wrap), (i == 1) ? 32'd1 : 32'd0);
      start = 1'b0;
      up    = 1'b1;
    end
    idle_inputs();
    tick();
    chk("dn.done_pulse", 32'(done), 32'd1);
    chk("dn.done_g", 32'(g), 32'b0001);
    chk("dn.done_busy", 32'(busy), 32'd0);
    tick();
    chk("dn.after_done", 32'(done), 32'd0);

    // Abort with a load at the 6th code.
    start = 1'b1;
    up    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("ab%0d.g", i), 32'(g), 32'(up_codes[i]));
      start = 1'b0;
    end
    load     = 1'b1;
    load_val = 4'd3;
    tick();
    chk("ab.load_g", 32'(g), 32'b0010);
    chk("ab.load_valid", 32'(valid), 32'd1);
    chk("ab.load_busy", 32'(busy), 32'd0);
    chk("ab.load_done", 32'(done), 32'd0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ab.idle%0d.done", i), 32'(done), 32'd0);
      chk($sformatf("ab.idle%0d.valid", i), 32'(valid), 32'd0);
      chk($sformatf("ab.idle%0d.g", i), 32'(g), 32'b0010);
    end
    start = 1'b1;
    up    = 1'b1;
    tick();
    chk("ab.restart_g", 32'(g), 32'b0000);
    chk("ab.restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("rs%0d.g", i), 32'(g), 32'(up_codes[i]));
    end

    // Asynchronous reset mid-sweep, checked before the next clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.g", 32'(g), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("post_rst%0d.g", i), 32'(g), 32'd0);
      chk($sformatf("post_rst%0d.valid", i), 32'(valid), 32'd0);
      chk($sformatf("post_rst%0d.busy", i), 32'(busy), 32'd0);
      chk($sformatf("post_rst%0d.done", i), 32'(done), 32'd0);
    end
    chk("final.err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
